sort_sequencer: RTL

//  Sorts four unsigned 3-bit values into ascending order using one shared ALU

---
 rtl/sort_sequencer_pkg.sv | 30 +++
 rtl/sort_sequencer_if.sv | 25 ++
 rtl/sort_sequencer_alu.sv | 43 ++++
 rtl/sort_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/sort_sequencer_pkg.sv
// Shared types and constants for the four-element sort sequencer.
// Holds FSM encodings, ALU opcodes and the compare-exchange schedule.
package sort_sequencer_pkg;

  localparam int W = 3;
  localparam int N = 4;
  localparam int STEPS = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMP0 = 3'd1,
    S_CMP1 = 3'd2,
    S_CMP2 = 3'd3,
    S_CMP3 = 3'd4,
    S_CMP4 = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [1:0] PAIR_I [0:STEPS-1] =
    '{2'd0, 2'd2, 2'd0, 2'd1, 2'd1};
  localparam logic [1:0] PAIR_J [0:STEPS-1] =
    '{2'd1, 2'd3, 2'd2, 2'd3, 2'd2};

endpackage

// File: rtl/sort_sequencer_if.sv
// Start/done handshake and data bundle for the sort sequencer.
// The slave side is the sequencer; the master side is source and consumer.
interface sort_sequencer_if
  import sort_sequencer_pkg::*;
();

  logic         start;
  logic [N*W-1:0] data_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N*W-1:0] data_out;
  logic [2:0]   swap_cnt;

  modport master (
    output start, data_in,
    input  ready, busy, done, data_out, swap_cnt
  );

  modport slave (
    input  start, data_in,
    output ready, busy, done, data_out, swap_cnt
  );

endinterface

// File: rtl/sort_sequencer_alu.sv
// Small shared ALU: add/sub/logic ops with carry, zero and overflow flags.
// For subtract, cf is the unsigned borrow (a < b).
module sort_sequencer_alu
  import sort_sequencer_pkg::*;
(
  input  logic [2:0]   s,
  input  logic         sign,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] yout,
  output logic         cf,
  output logic         z,
  output logic         v
);

  logic [W:0] ext;

  always_comb begin
    ext = '0;
    v   = 1'b0;
    unique case (s)
      ALU_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        v = sign & (a[W-1] == b[W-1])
              & (ext[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        v = sign & (a[W-1] != b[W-1])
              & (ext[W-1] != a[W-1]);
      end
      ALU_AND: ext = {1'b0, a & b};
      ALU_OR:  ext = {1'b0, a | b};
      ALU_XOR: ext = {1'b0, a ^ b};
      default: ext = {1'b0, a};
    endcase
  end

  assign yout = ext[W-1:0];
  assign cf   = ext[W];
  assign z    = (ext[W-1:0] == '0);

endmodule

// File: rtl/sort_sequencer.sv
// Four-element ascending sorter using one shared subtract ALU.
// Runs a fixed 5-step compare-exchange network, one compare per cycle.
module sort_sequencer
  import sort_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  sort_sequencer_if.slave bus
);

  state_t       state, state_n;
  logic [2:0]   step, step_n;
  logic [W-1:0] r [N];
  logic [2:0]   cnt;
  logic         load;
  logic         busy;
  logic [1:0]   ia, ib;
  logic [W-1:0] ra, rb;
  logic         cf, z;
  logic         do_swap;
  logic [W-1:0] alu_unused_y;
  logic         alu_unused_v;

  assign ia = PAIR_I[step];
  assign ib = PAIR_J[step];
  assign ra = r[ia];
  assign rb = r[ib];

  sort_sequencer_alu u_alu (
    .s    (ALU_SUB),
    .sign (1'b0),
    .a    (ra),
    .b    (rb),
    .yout (alu_unused_y),
    .cf   (cf),
    .z    (z),
    .v    (alu_unused_v)
  );

  // a > b unsigned: no borrow and not equal, so ties stay put
  assign do_swap = busy & ~cf & ~z;

  always_comb begin
    state_n = state;
    step_n  = step;
    load    = 1'b0;
    busy    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_CMP0;
          step_n  = '0;
          load    = 1'b1;
        end
      end
      S_CMP0: begin
        busy    = 1'b1;
        state_n = S_CMP1;
        step_n  = 3'(step + 3'd1);
      end
      S_CMP1: begin
        busy    = 1'b1;
        state_n = S_CMP2;
        step_n  = 3'(step + 3'd1);
      end
      S_CMP2: begin
        busy    = 1'b1;
        state_n = S_CMP3;
        step_n  = 3'(step + 3'd1);
      end
      S_CMP3: begin
        busy    = 1'b1;
        state_n = S_CMP4;
        step_n  = 3'(step + 3'd1);
      end
      S_CMP4: begin
        busy    = 1'b1;
        state_n = S_DONE;
        step_n  = '0;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      step  <= '0;
      cnt   <= '0;
      for (int k = 0; k < N; k++) r[k] <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
      if (load) begin
        cnt <= '0;
        for (int k = 0; k < N; k++)
          r[k] <= bus.data_in[k*W +: W];
      end else if (do_swap) begin
        r[ia] <= rb;
        r[ib] <= ra;
        cnt   <= 3'(cnt + 3'd1);
      end
    end
  end

  assign bus.ready    = (state == S_IDLE);
  assign bus.busy     = busy;
  assign bus.done     = (state == S_DONE);
  assign bus.swap_cnt = cnt;
  assign bus.data_out = {r[3], r[2], r[1], r[0]};

endmodule
